// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_DIVU = 2'b01,
    OP_MULS = 2'b10,
    OP_DIVS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a hi:lo accumulator pair.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_s;
  logic [WIDTH:0] diff_s;

  // Single iteration; diff_s[WIDTH] is the borrow of the trial subtract.
  always_comb begin
    sum_s  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    rem_s  = {acc_hi, acc_lo[WIDTH-1]};
    diff_s = rem_s - {1'b0, operand};
    if (is_div) begin
      if (diff_s[WIDTH]) begin
        next_hi = rem_s[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end else begin
        next_hi = diff_s[WIDTH-1:0];
        next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      next_hi = sum_s[WIDTH:1];
      next_lo = {sum_s[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide controller: accepts one op, iterates WIDTH times,
// then presents sign-corrected registered results with a one-cycle done pulse.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_r, state_s;
  logic [CW-1:0]    count_r, count_s;
  logic             is_div_r, is_div_s;
  logic             neg_q_r, neg_q_s;
  logic             neg_r_r, neg_r_s;
  logic [WIDTH-1:0] mag_r, mag_s;
  logic [WIDTH-1:0] acc_hi_r, acc_hi_s;
  logic [WIDTH-1:0] acc_lo_r, acc_lo_s;
  logic             busy_s, done_s, dbz_s;
  logic [WIDTH-1:0] res_lo_s, res_hi_s;
  logic [WIDTH-1:0] step_hi_s, step_lo_s;
  logic             op_div_s, op_signed_s, sign_a_s, sign_b_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_r),
    .acc_hi  (acc_hi_r),
    .acc_lo  (acc_lo_r),
    .operand (mag_r),
    .next_hi (step_hi_s),
    .next_lo (step_lo_s)
  );

  // Operand decode for the accept cycle and final product sign fix.
  always_comb begin
    op_div_s    = (op == OP_DIVU) || (op == OP_DIVS);
    op_signed_s = (op == OP_MULS) || (op == OP_DIVS);
    sign_a_s    = op_signed_s & operand_a[WIDTH-1];
    sign_b_s    = op_signed_s & operand_b[WIDTH-1];
    abs_a_s     = sign_a_s ? (~operand_a + WIDTH'(1)) : operand_a;
    abs_b_s     = sign_b_s ? (~operand_b + WIDTH'(1)) : operand_b;
    prod_s      = {step_hi_s, step_lo_s};
    prod_fix_s  = neg_q_r ? (~prod_s + (2*WIDTH)'(1)) : prod_s;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    is_div_s = is_div_r;
    neg_q_s  = neg_q_r;
    neg_r_s  = neg_r_r;
    mag_s    = mag_r;
    acc_hi_s = acc_hi_r;
    acc_lo_s = acc_lo_r;
    busy_s   = busy;
    done_s   = 1'b0;
    dbz_s    = div_by_zero;
    res_lo_s = result_lo;
    res_hi_s = result_hi;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          if (op_div_s && (operand_b == {WIDTH{1'b0}})) begin
            state_s  = DONE;
            busy_s   = 1'b0;
            done_s   = 1'b1;
            dbz_s    = 1'b1;
            res_lo_s = {WIDTH{1'b1}};
            res_hi_s = operand_a;
          end else begin
            state_s  = RUN;
            busy_s   = 1'b1;
            dbz_s    = 1'b0;
            count_s  = CW'(WIDTH-1);
            is_div_s = op_div_s;
            neg_q_s  = sign_a_s ^ sign_b_s;
            neg_r_s  = sign_a_s;
            mag_s    = op_div_s ? abs_b_s : abs_a_s;
            acc_hi_s = {WIDTH{1'b0}};
            acc_lo_s = op_div_s ? abs_a_s : abs_b_s;
          end
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end
      RUN: begin
        acc_hi_s = step_hi_s;
        acc_lo_s = step_lo_s;
        if (count_r == {CW{1'b0}}) begin
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          if (is_div_r) begin
            res_lo_s = neg_q_r ? (~step_lo_s + WIDTH'(1)) : step_lo_s;
            res_hi_s = neg_r_r ? (~step_hi_s + WIDTH'(1)) : step_hi_s;
          end else begin
            res_lo_s = prod_fix_s[WIDTH-1:0];
            res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
          end
        end else begin
          count_s = count_r - CW'(1);
          busy_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      is_div_r    <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      mag_r       <= {WIDTH{1'b0}};
      acc_hi_r    <= {WIDTH{1'b0}};
      acc_lo_r    <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result_lo   <= {WIDTH{1'b0}};
      result_hi   <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      is_div_r    <= is_div_s;
      neg_q_r     <= neg_q_s;
      neg_r_r     <= neg_r_s;
      mag_r       <= mag_s;
      acc_hi_r    <= acc_hi_s;
      acc_lo_r    <= acc_lo_s;
      busy        <= busy_s;
      done        <= done_s;
      div_by_zero <= dbz_s;
      result_lo   <= res_lo_s;
      result_hi   <= res_hi_s;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] operand_a = 32'd0;
  logic [W-1:0] operand_b = 32'd0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] lo, output logic [31:0] hi, output logic dbz);
    logic [63:0]        p;
    logic signed [63:0] sa, sb, q, r;
    dbz = 1'b0;
    lo  = 32'd0;
    hi  = 32'd0;
    case (o)
      2'b00: begin
        p  = {32'd0, a} * {32'd0, b};
        lo = p[31:0];
        hi = p[63:32];
      end
      2'b10: begin
        p  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        lo = p[31:0];
        hi = p[63:32];
      end
      default: begin
        if (b == 32'd0) begin
          lo  = 32'hFFFF_FFFF;
          hi  = a;
          dbz = 1'b1;
        end else if (o == 2'b01) begin
          lo = a / b;
          hi = a % b;
        end else begin
          sa = {{32{a[31]}}, a};
          sb = {{32{b[31]}}, b};
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit mid_pulse);
    logic [31:0] elo, ehi;
    logic        edbz;
    int          cycles, busy_cnt;
    model(o, a, b, elo, ehi, edbz);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
    cycles = 0; busy_cnt = 0;
    while (!done && cycles < 60) begin
      if (busy) busy_cnt++;
      if (mid_pulse && cycles == 10) begin
        start = 1'b1; operand_a = $urandom; operand_b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(cycles + 1), edbz ? 64'd1 : 64'(W + 1));
    check({tag, " busy cycles"}, 64'(busy_cnt), edbz ? 64'd0 : 64'(W));
    check({tag, " result_lo"}, {32'd0, result_lo}, {32'd0, elo});
    check({tag, " result_hi"}, {32'd0, result_hi}, {32'd0, ehi});
    check({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, edbz});
    @(posedge clk); #1;
    check({tag, " done pulse width"}, {63'd0, done}, 64'd0);
    check({tag, " result hold"}, {result_hi, result_lo}, {ehi, elo});
  endtask

  initial begin
    logic [31:0] elo1, ehi1, elo2, ehi2;
    logic        edbz1, edbz2;
    int          cycles, done_seen;

    #1;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset results", {result_hi, result_lo}, 64'd0);
    check("reset dbz", {63'd0, div_by_zero}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu max", 1'b0);
    run_op(2'b01, 32'd100, 32'd7, "divu 100/7", 1'b0);
    run_op(2'b11, 32'hFFFF_FF9C, 32'd7, "divs -100/7", 1'b0);
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, "muls -3*5", 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "divs min/-1", 1'b0);
    run_op(2'b01, 32'h0000_1234, 32'd0, "divu by zero", 1'b0);
    run_op(2'b11, 32'hFFFF_FF00, 32'd0, "divs by zero", 1'b0);
    run_op(2'b00, 32'd123457, 32'd98765, "mulu mid start", 1'b1);

    // Reset asserted ten cycles into a multiply.
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2; reset = 1'b0; #1;
    check("midrun reset busy", {63'd0, busy}, 64'd0);
    check("midrun reset done", {63'd0, done}, 64'd0);
    check("midrun reset results", {result_hi, result_lo}, 64'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abandoned op no done", 64'(done_seen), 64'd0);
    run_op(2'b00, 32'd7, 32'd6, "mulu 7*6 after reset", 1'b0);

    // Back-to-back with start held high through DONE.
    model(2'b00, 32'd123456, 32'd789, elo1, ehi1, edbz1);
    model(2'b11, 32'hFFFF_FC18, 32'd33, elo2, ehi2, edbz2);
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd123456; operand_b = 32'd789;
    @(posedge clk); #1;
    cycles = 0;
    while (!done && cycles < 60) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("b2b first latency", 64'(cycles + 1), 64'(W + 1));
    check("b2b first result", {result_hi, result_lo}, {ehi1, elo1});
    op = 2'b11; operand_a = 32'hFFFF_FC18; operand_b = 32'd33;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 60) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("b2b done spacing", 64'(cycles + 1), 64'(W + 1));
    check("b2b second result", {result_hi, result_lo}, {ehi2, elo2});
    check("b2b second dbz", {63'd0, div_by_zero}, {63'd0, edbz2});

    // Randomized operations, with occasional zero / small / all-ones divisors.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, $sformatf("random %0d op %0d", i, ro), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller that sequences the iterative multiply/divide datapath of the 32-bit computer. The execute stage issues one operation with a start pulse. The block runs a fixed WIDTH-iteration shift-add multiply or restoring divide, then returns a 2×WIDTH result with a one-cycle done pulse. It sits beside the ALU. It stalls the computer through `busy` so the register file writes back only on `done`.

## Interface
- WIDTH, 32, operand width; the iteration count equals WIDTH.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  00 MULU, 01 DIVU, 10 MULS, 11 DIVS.
- operand_a  input  WIDTH  multiplicand / dividend.
- operand_b  input  WIDTH  multiplier / divisor.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results are valid this cycle.
- result_lo  output  WIDTH  product low half / quotient.
- result_hi  output  WIDTH  product high half / remainder.
- div_by_zero  output  1  valid with done; set for a divide with operand_b == 0.

## Operation
- States: IDLE, RUN, DONE.
- Reset (reset = 0, asynchronous):
  - state returns to IDLE; the iteration counter clears.
  - busy, done, div_by_zero, result_lo and result_hi all go to 0.
  - Any operation in flight is abandoned with no done pulse.
- IDLE, start = 1:
  - latch op and the operand magnitudes; signed ops take two's-complement absolute values.
  - latch the result signs: product/quotient sign = sign(a) ^ sign(b); remainder sign = sign(a).
  - counter = WIDTH−1; go to RUN.
- IDLE, start = 0: stay in IDLE.
- Divide with operand_b == 0:
  - go directly to DONE without entering RUN.
  - result_lo = all ones; result_hi = operand_a unmodified; div_by_zero = 1.
- RUN, one iteration per cycle:
  - Multiply: conditional add of the multiplicand into the high accumulator, then a 2×WIDTH right shift.
  - Divide: left-shift the remainder:quotient pair, trial-subtract the divisor, set the quotient bit and restore on borrow.
  - At counter == 0, go to DONE; otherwise decrement.
- DONE:
  - done = 1 and sign correction is applied to the registered results.
  - Results hold until the next accepted start.
  - If start = 1 in DONE, a new op is accepted (back-to-back) and the state goes to RUN; otherwise it goes to IDLE.
- start while in RUN is ignored; the requester must hold it until busy drops.
- Arithmetic:
  - the product is the exact 2×WIDTH result.
  - signed divide truncates toward zero.
  - −2^31 / −1 gives quotient 0x80000000 and remainder 0, with no flag.
- Operand inputs are don't-care except in the accept cycle.

## Timing
- Start accepted at edge E0:
  - busy = 1 from after E0 through edge E_WIDTH.
  - done = 1 in the cycle after edge E_WIDTH; latency is WIDTH+1 cycles (33 at WIDTH=32).
- Divide by zero: done in the cycle after E0; busy stays 0.
- Back-to-back: with start held high in DONE, the next done follows exactly WIDTH+1 cycles later.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-RUN: outputs are 0 immediately (asynchronous); after release the first accepted start behaves normally.

## Structure
- Package muldiv_pkg holds:
  - the op encodings OP_MULU, OP_DIVU, OP_MULS, OP_DIVS;
  - the state encoding (IDLE/RUN/DONE);
  - the default WIDTH.
- One natural sub-module, muldiv_step: the combinational single-iteration step for shift-add / restoring-subtract, selected by a mul/div input.
- The sequencer owns the FSM, counter, sign latches and result registers.

## Test plan
- Reset during RUN (cycle 10 of a MULU): busy/done/results drop to 0 immediately; no done pulse; next op 7×6 gives result_lo 42.
- MULU 0xFFFFFFFF × 0xFFFFFFFF → done at cycle 33 after the start edge, result_hi 0xFFFFFFFE, result_lo 0x00000001, busy high for 32 cycles.
- DIVU 100 / 7 → result_lo 14, result_hi 2, div_by_zero 0; then DIVS −100 / 7 → result_lo 0xFFFFFFF2 (−14), result_hi 0xFFFFFFFE (−2).
- MULS −3 × 5 → result_hi 0xFFFFFFFF, result_lo 0xFFFFFFF1; DIVS 0x80000000 / −1 → result_lo 0x80000000, result_hi 0.
- DIVU 0x1234 / 0 → done the next cycle, busy never high, result_lo 0xFFFFFFFF, result_hi 0x1234, div_by_zero 1.
- Start pulsed mid-RUN is ignored (results unchanged); start held through DONE gives back-to-back ops with done pulses exactly 33 cycles apart.
